// File: rtl/risc_pkg.sv
// ---------------------------------------------------------------------------
// risc_pkg
// Shared encodings for the execute stage:
//   - DEFAULT_WIDTH : default datapath width
//   - aluop_e       : ALU operation encodings (aluop input)
//   - shift_e       : B-operand shift encodings (shift input)
//   - state_e       : multiplier sequencing states
// ---------------------------------------------------------------------------
package risc_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_NOT = 3'b011,
    ALU_MUL = 3'b100
  } aluop_e;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL1 = 2'b01,
    SH_LSR1 = 2'b10,
    SH_ASR1 = 2'b11
  } shift_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_MUL    = 2'b01,
    ST_FINISH = 2'b10
  } state_e;

endpackage

// File: rtl/shifter_unit.sv
// ---------------------------------------------------------------------------
// shifter_unit
// Combinational one-bit shifter for the B operand.
// Ports:
//   b_i     [WIDTH-1:0]  operand to shift
//   shift_i [1:0]        00 none, 01 LSL1, 10 LSR1 (zero fill), 11 ASR1
//   b_o     [WIDTH-1:0]  shifted operand
// ---------------------------------------------------------------------------
module shifter_unit
  import risc_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] b_i,
  input  logic [1:0]       shift_i,
  output logic [WIDTH-1:0] b_o
);

  // Shift selection
  always_comb begin
    b_o = b_i;
    case (shift_i)
      SH_NONE: b_o = b_i;
      SH_LSL1: b_o = {b_i[WIDTH-2:0], 1'b0};
      SH_LSR1: b_o = {1'b0, b_i[WIDTH-1:1]};
      SH_ASR1: b_o = {b_i[WIDTH-1], b_i[WIDTH-1:1]};
      default: b_o = b_i;
    endcase
  end

endmodule

// File: rtl/execute_unit.sv
// ---------------------------------------------------------------------------
// execute_unit
// ALU execute stage: operand selection, single-cycle ADD/SUB/AND/NOT and an
// optional iterative unsigned shift-add multiplier.
// Build option: define EXECUTE_UNIT_MUL_EN to include the multiplier; when
// undefined, aluop 100 behaves like any reserved op and busy is tied low.
// Ports:
//   clk, reset (async, active high), start (request, sampled on rising clk)
//   A, B, sximm5 [WIDTH-1:0]  operands / sign-extended immediate
//   asel (zero for A), bsel (sximm5 for shifted B), shift [1:0], aluop [2:0]
//   loads       allow status update for this operation
//   C [WIDTH-1:0] result register, status [2:0] = {V,N,Z}
//   busy        multi-cycle operation in progress
//   done        one-cycle pulse: new result on C
// ---------------------------------------------------------------------------
module execute_unit
  import risc_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] sximm5,
  input  logic             asel,
  input  logic             bsel,
  input  logic [1:0]       shift,
  input  logic [2:0]       aluop,
  input  logic             loads,
  output logic [WIDTH-1:0] C,
  output logic [2:0]       status,
  output logic             busy,
  output logic             done
);

  function automatic logic [2:0] make_status(input logic v, input logic [WIDTH-1:0] r);
    return {v, r[WIDTH-1], (r == '0)};
  endfunction

  logic [WIDTH-1:0] c_q, c_d;
  logic [2:0]       status_q, status_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] ain_s, bsh_s, bin_s, res_s;
  logic             v_s;
  logic             busy_s, accept_s;

  assign ain_s = asel ? '0 : A;
  assign bin_s = bsel ? sximm5 : bsh_s;

  shifter_unit #(.WIDTH(WIDTH)) u_shifter (
    .b_i     (B),
    .shift_i (shift),
    .b_o     (bsh_s)
  );

  // Single-cycle ALU result and overflow flag
  always_comb begin
    res_s = '0;
    v_s   = 1'b0;
    case (aluop)
      ALU_ADD: begin
        res_s = ain_s + bin_s;
        v_s   = (ain_s[WIDTH-1] == bin_s[WIDTH-1]) && (res_s[WIDTH-1] != ain_s[WIDTH-1]);
      end
      ALU_SUB: begin
        res_s = ain_s - bin_s;
        v_s   = (ain_s[WIDTH-1] != bin_s[WIDTH-1]) && (res_s[WIDTH-1] != ain_s[WIDTH-1]);
      end
      ALU_AND: begin
        res_s = ain_s & bin_s;
        v_s   = 1'b0;
      end
      ALU_NOT: begin
        res_s = ~bin_s;
        v_s   = 1'b0;
      end
      // Reserved codes (and MUL when it is not built) give zero, so status becomes {0,0,1}.
      default: begin
        res_s = '0;
        v_s   = 1'b0;
      end
    endcase
  end

`ifdef EXECUTE_UNIT_MUL_EN
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic               mloads_q, mloads_d;
  logic [2*WIDTH-1:0] prod_s;
  logic               is_mul_s;

  // FINISH counts as not busy, so a new request may be accepted there.
  assign busy_s   = (state_q == ST_MUL);
  assign accept_s = start && !busy_s;
  assign is_mul_s = (aluop == ALU_MUL);
  // Accumulator including this edge's partial product; at the last edge it is the full product.
  assign prod_s   = acc_q + (mplier_q[0] ? mcand_q : '0);

  // Next-state, result and multiplier datapath control
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    mloads_d = mloads_q;
    c_d      = c_q;
    status_d = status_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE, ST_FINISH: begin
        state_d = ST_IDLE;
        if (accept_s) begin
          if (is_mul_s) begin
            state_d  = ST_MUL;
            cnt_d    = '0;
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, ain_s};
            mplier_d = bin_s;
            mloads_d = loads;
          end else begin
            c_d    = res_s;
            done_d = 1'b1;
            if (loads) begin
              status_d = make_status(v_s, res_s);
            end else begin
              status_d = status_q;
            end
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL: begin
        acc_d    = prod_s;
        mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) begin
          state_d = ST_FINISH;
          c_d     = prod_s[WIDTH-1:0];
          done_d  = 1'b1;
          if (mloads_q) begin
            status_d = make_status(|prod_s[2*WIDTH-1:WIDTH], prod_s[WIDTH-1:0]);
          end else begin
            status_d = status_q;
          end
        end else begin
          state_d = ST_MUL;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Multiplier state, counter and accumulators
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      mloads_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      mloads_q <= mloads_d;
    end
  end
`else
  assign busy_s   = 1'b0;
  assign accept_s = start;

  // Result and status update for single-cycle operations
  always_comb begin
    c_d      = c_q;
    status_d = status_q;
    done_d   = 1'b0;
    if (accept_s) begin
      c_d    = res_s;
      done_d = 1'b1;
      if (loads) begin
        status_d = make_status(v_s, res_s);
      end else begin
        status_d = status_q;
      end
    end else begin
      done_d = 1'b0;
    end
  end
`endif

  // Result, status and done registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_q      <= '0;
      status_q <= 3'b000;
      done_q   <= 1'b0;
    end else begin
      c_q      <= c_d;
      status_q <= status_d;
      done_q   <= done_d;
    end
  end

  assign C      = c_q;
  assign status = status_q;
  assign done   = done_q;
  assign busy   = busy_s;

endmodule

// File: tb/tb_execute_unit.sv
// ---------------------------------------------------------------------------
// tb_execute_unit
// Directed self-checking bench for execute_unit (WIDTH = 16). Inputs change
// and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_execute_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] A, B, sximm5;
  logic        asel, bsel;
  logic [1:0]  shift;
  logic [2:0]  aluop;
  logic        loads;
  logic [15:0] C;
  logic [2:0]  status;
  logic        busy, done;

  int n_cmp = 0;
  int n_err = 0;

  execute_unit #(.WIDTH(16)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .A      (A),
    .B      (B),
    .sximm5 (sximm5),
    .asel   (asel),
    .bsel   (bsel),
    .shift  (shift),
    .aluop  (aluop),
    .loads  (loads),
    .C      (C),
    .status (status),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] imm, input logic as, input logic bs,
                       input logic [1:0] sh, input logic ld);
    aluop = op; A = a; B = b; sximm5 = imm; asel = as; bsel = bs; shift = sh; loads = ld;
    start = 1'b1;
  endtask

  // One single-cycle operation: done must pulse for exactly one cycle.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] imm, input logic as,
                        input logic bs, input logic [1:0] sh, input logic ld,
                        input logic [15:0] exp_c, input logic [2:0] exp_s);
    drive(op, a, b, imm, as, bs, sh, ld);
    @(negedge clk);
    start = 1'b0;
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_C"}, 32'(C), 32'(exp_c));
    check({tag, "_status"}, 32'(status), 32'(exp_s));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    @(negedge clk);
    check({tag, "_done_clr"}, 32'(done), 32'd0);
  endtask

  initial begin
    int seen;
    reset = 1'b1; start = 1'b0;
    A = 16'h0; B = 16'h0; sximm5 = 16'h0; asel = 1'b0; bsel = 1'b0;
    shift = 2'b00; aluop = 3'b000; loads = 1'b0;
    #3;
    check("rst_C", 32'(C), 32'd0);
    check("rst_status", 32'(status), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    run_op("add5p3", 3'b000, 16'h0005, 16'h0003, 16'h0, 1'b0, 1'b0, 2'b00, 1'b1, 16'h0008, 3'b000);
    run_op("sub_ovf", 3'b001, 16'h7FFF, 16'hFFFF, 16'h0, 1'b0, 1'b0, 2'b00, 1'b1, 16'h8000, 3'b110);
    run_op("add_lsl_noload", 3'b000, 16'h1234, 16'h4000, 16'h0, 1'b1, 1'b0, 2'b01, 1'b0, 16'h8000, 3'b110);
    run_op("and_lsr", 3'b010, 16'hF0F0, 16'hFF00, 16'h0, 1'b0, 1'b0, 2'b10, 1'b1, 16'h7080, 3'b000);
    run_op("not_imm", 3'b011, 16'h1111, 16'h2222, 16'hFFFF, 1'b0, 1'b1, 2'b00, 1'b1, 16'h0000, 3'b001);
    run_op("not_asr", 3'b011, 16'h0000, 16'h8002, 16'h0, 1'b0, 1'b0, 2'b11, 1'b1, 16'h3FFE, 3'b000);
    run_op("add_ovf", 3'b000, 16'h7FFF, 16'h0001, 16'h0, 1'b0, 1'b0, 2'b00, 1'b1, 16'h8000, 3'b110);
    run_op("add_wrap", 3'b000, 16'hFFFF, 16'h0001, 16'h0, 1'b0, 1'b0, 2'b00, 1'b1, 16'h0000, 3'b001);
    run_op("add_set", 3'b000, 16'h0010, 16'h0020, 16'h0, 1'b0, 1'b0, 2'b00, 1'b1, 16'h0030, 3'b000);
    run_op("reserved101", 3'b101, 16'h1234, 16'h5678, 16'h0, 1'b0, 1'b0, 2'b00, 1'b1, 16'h0000, 3'b001);

    // Back-to-back single-cycle starts
    drive(3'b000, 16'h0001, 16'h0001, 16'h0, 1'b0, 1'b0, 2'b00, 1'b1);
    @(negedge clk);
    check("b2b_1_done", 32'(done), 32'd1);
    check("b2b_1_C", 32'(C), 32'h0002);
    A = 16'h0002; B = 16'h0002;
    @(negedge clk);
    start = 1'b0;
    check("b2b_2_done", 32'(done), 32'd1);
    check("b2b_2_C", 32'(C), 32'h0004);
    @(negedge clk);
    check("b2b_done_clr", 32'(done), 32'd0);

`ifdef EXECUTE_UNIT_MUL_EN
    // MUL 300*300 = 0x15F90; a start issued mid-operation must be ignored
    drive(3'b100, 16'd300, 16'd300, 16'h0, 1'b0, 1'b0, 2'b00, 1'b1);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check($sformatf("mul_busy_%0d", i), 32'(busy), 32'd1);
      check($sformatf("mul_nodone_%0d", i), 32'(done), 32'd0);
      if (i == 0) begin
        start = 1'b0; A = 16'h0000; B = 16'h0000;
      end else if (i == 3) begin
        start = 1'b1; aluop = 3'b000; A = 16'h0003; B = 16'h0004;
      end else if (i == 4) begin
        start = 1'b0;
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    check("mul_busy_end", 32'(busy), 32'd0);
    check("mul_done", 32'(done), 32'd1);
    check("mul_C", 32'(C), 32'h5F90);
    check("mul_status", 32'(status), 32'b100);
    @(negedge clk);
    check("mul_done_clr", 32'(done), 32'd0);

    // Reset after the fifth iteration aborts the MUL
    drive(3'b100, 16'd300, 16'd300, 16'h0, 1'b0, 1'b0, 2'b00, 1'b1);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) @(negedge clk);
    check("mulrst_busy_pre", 32'(busy), 32'd1);
`else
    // aluop 100 acts as reserved when the multiplier is not built
    run_op("mul_off", 3'b100, 16'd300, 16'd300, 16'h0, 1'b0, 1'b0, 2'b00, 1'b1, 16'h0000, 3'b001);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("mul_off_busy_%0d", i), 32'(busy), 32'd0);
    end
    run_op("pre_rst", 3'b000, 16'h7FFF, 16'h0001, 16'h0, 1'b0, 1'b0, 2'b00, 1'b1, 16'h8000, 3'b110);
`endif

    // Asynchronous reset clears everything immediately
    #2 reset = 1'b1;
    #1;
    check("arst_C", 32'(C), 32'd0);
    check("arst_status", 32'(status), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    check("arst_no_done", 32'(seen), 32'd0);
    run_op("post_rst_add", 3'b000, 16'h0001, 16'h0001, 16'h0, 1'b0, 1'b0, 2'b00, 1'b1, 16'h0002, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/execute_unit.md
EXECUTE_UNIT -- requirements
Module: execute_unit

Interface
REQ-001 Parameter: WIDTH, default 16, datapath width in bits.
REQ-002 clk  input  1  rising-edge clock, the single clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  operation request, sampled on rising clk.
REQ-005 A  input  WIDTH  operand A from the A holding register.
REQ-006 B  input  WIDTH  operand B from the B holding register.
REQ-007 sximm5  input  WIDTH  sign-extended immediate.
REQ-008 asel  input  1  1 selects zero in place of A.
REQ-009 bsel  input  1  1 selects sximm5 in place of shifted B.
REQ-010 shift  input  2  B shift: 00 none, 01 LSL1, 10 LSR1 (zero fill), 11 ASR1.
REQ-011 aluop  input  3  000 ADD, 001 SUB, 010 AND, 011 NOT Bin, 100 MUL; others reserved.
REQ-012 loads  input  1  1 lets the operation update status.
REQ-013 C  output  WIDTH  result register.
REQ-014 status  output  3  {V,N,Z} status register.
REQ-015 busy  output  1  high while a multi-cycle operation is in progress.
REQ-016 done  output  1  one-cycle pulse marking a new result on C.

Function
REQ-017 Operand formation: Ain = asel ? 0 : A; Bin = bsel ? sximm5 : shift(B); all fields are sampled at the accepting edge.
REQ-018 A start accepted while busy=0 at a rising edge with a non-MUL op: C and status load at that same edge; done=1 for the following cycle.
REQ-019 A start while busy=1 is ignored: no capture and no effect on the operation in progress.
REQ-020 ADD/SUB: modulo 2^WIDTH; V = two's-complement signed overflow.
REQ-021 AND/NOT: V=0.
REQ-022 N = result MSB; Z = (result == 0).
REQ-023 Status loads only if loads=1 at acceptance; otherwise status holds its value; C always loads.
REQ-024 MUL is unsigned iterative shift-add and uses FSM states IDLE, MUL, FINISH.
REQ-025 MUL, acceptance edge E0: capture Ain and Bin, enter MUL, set busy=1.
REQ-026 MUL: one partial product per edge, E1..EWIDTH.
REQ-027 MUL, at EWIDTH: C = low WIDTH bits of the product; V=1 if the high WIDTH bits are nonzero; N and Z from C.
REQ-028 MUL: state passes through FINISH to IDLE; busy=0 and done=1 in the cycle after EWIDTH.
REQ-029 Reserved aluop values: C=0; status, if loaded, = {0,0,1}; single-cycle timing.
REQ-030 done is never asserted in two consecutive cycles for a MUL; back-to-back single-cycle starts give back-to-back done pulses.

Reset
REQ-031 While reset=1: C=0, status=0, busy=0, done=0, FSM=IDLE, iteration counter and multiplier accumulators cleared; acts immediately, regardless of clk.
REQ-032 Reset mid-MUL aborts the operation with no done pulse; the first start after reset deasserts is accepted normally.

Configuration
REQ-033 Macro EXECUTE_UNIT_MUL_EN defined: MUL is built as specified in REQ-024 to REQ-028.
REQ-034 EXECUTE_UNIT_MUL_EN undefined: no multiplier logic; aluop 100 behaves as reserved (REQ-029); busy is tied to 0.

Structure
REQ-035 Package risc_pkg holds the aluop and shift encodings, the FSM state type and the WIDTH default.
REQ-036 Sub-module shifter_unit (combinational, WIDTH-parameterised) implements the B shift.
REQ-037 All other logic resides in execute_unit.

Verification
REQ-038 ADD, A=0x0005, B=0x0003, shift=00, bsel=0, loads=1 -> C=0x0008, status=000, done one cycle after the accepting edge.
REQ-039 SUB, A=0x7FFF, B=0xFFFF -> C=0x8000, status={V=1,N=1,Z=0}.
REQ-040 ADD, asel=1, B=0x4000, shift=01 -> C=0x8000; with loads=0 status holds its prior value.
REQ-041 MUL (macro on), A=300, B=300 -> busy high for WIDTH cycles, C=0x5F90, V=1, done WIDTH+1 cycles after acceptance; a start issued mid-operation is ignored.
REQ-042 Reset asserted at MUL iteration 5 -> C=0, status=0, busy=0 immediately, no done pulse; a following ADD 1+1 gives C=0x0002.
REQ-043 Macro off, aluop=100 -> C=0, status=001, busy never high.
